// File: rtl/busout_nibble_scanner.sv
// busout_nibble_scanner: captures a multi-nibble BUSOUT value and scans it,
// one nibble per refresh slot, onto a shared seven-segment decoder.
// Ports: clock_i, resetn_i (sync, active-low), busin_i, load_i, freeze_i,
//        ack_o (capture pulse), nibble_o, anode_o (active-low), digit_o.
// Option: define BUSOUT_SCAN_BLANK_EN for leading-zero blanking.
module busout_nibble_scanner #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000
) (
  input  logic                  clock_i,
  input  logic                  resetn_i,
  input  logic [4*DIGITS-1:0]   busin_i,
  input  logic                  load_i,
  input  logic                  freeze_i,
  output logic                  ack_o,
  output logic [3:0]            nibble_o,
  output logic [DIGITS-1:0]     anode_o,
  output logic [1:0]            digit_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);
  localparam logic [1:0]    ILAST = 2'(DIGITS - 1);

  logic [4*DIGITS-1:0] cap_q, cap_d;
  logic [PW-1:0]       pcnt_q, pcnt_d;
  logic [1:0]          idx_q, idx_d;
  logic                ack_q, ack_d;

  always_comb begin
    cap_d  = cap_q;
    pcnt_d = pcnt_q;
    idx_d  = idx_q;
    ack_d  = load_i;
    if (load_i) begin
      cap_d = busin_i;
    end
    if (!freeze_i) begin
      if (pcnt_q == PLAST) begin
        pcnt_d = '0;
        idx_d  = (idx_q == ILAST) ? 2'd0 : idx_q + 2'd1;
      end else begin
        pcnt_d = pcnt_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (!resetn_i) begin
      cap_q  <= '0;
      pcnt_q <= '0;
      idx_q  <= '0;
      ack_q  <= 1'b0;
    end else begin
      cap_q  <= cap_d;
      pcnt_q <= pcnt_d;
      idx_q  <= idx_d;
      ack_q  <= ack_d;
    end
  end

  logic blank;

`ifdef BUSOUT_SCAN_BLANK_EN
  // A slot is dark when it and every higher nibble are zero; slot 0 never is.
  always_comb begin
    blank = (idx_q != 2'd0);
    for (int k = 0; k < DIGITS; k++) begin
      if (2'(k) >= idx_q && cap_q[4*k +: 4] != 4'h0) begin
        blank = 1'b0;
      end
    end
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    nibble_o = 4'h0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == 2'(k)) begin
        nibble_o = cap_q[4*k +: 4];
      end
    end
  end

  always_comb begin
    anode_o = '1;
    for (int k = 0; k < DIGITS; k++) begin
      anode_o[k] = blank | (idx_q != 2'(k));
    end
  end

  assign digit_o = idx_q;
  assign ack_o   = ack_q;

endmodule

// File: doc/busout_nibble_scanner.md
# busout_nibble_scanner

Upstream feeder for the BUSOUT seven-segment decoder. Captures the CPU's multi-nibble BUSOUT value on a load strobe and time-multiplexes one 4-bit nibble at a time onto the decoder input. It drives the matching active-low digit anode so a single decoder serves all display digits. A prescaled refresh counter steps the digit scan; an optional leading-zero blanking feature suppresses unused high digits.

## Interface
- DIGITS, 4: number of display digits scanned (legal 2..4); bus width is 4*DIGITS.
- PRESCALE, 50000: clock cycles per digit slot (legal >= 1).

- CLOCK  input  1  sole clock; all state updates on rising edge.
- RESETN  input  1  reset, synchronous, active-low.
- BUSIN  input  4*DIGITS  BUSOUT value to display; digit 0 = BUSIN[3:0].
- LOAD  input  1  capture strobe; samples BUSIN at the rising edge where LOAD=1.
- FREEZE  input  1  when 1, the refresh prescaler and digit index hold.
- ACK  output  1  one-cycle pulse the cycle after each capture.
- NIBBLE  output  4  nibble for the current digit, to decoder INARR.
- ANODE  output  DIGITS  one-hot active-low digit enable.
- DIGIT  output  2  current digit index.

## Operation
- State: capture register CAP (4*DIGITS), prescaler PCNT (0..PRESCALE-1), digit index IDX (0..DIGITS-1), ACK flop.
- Reset (RESETN=0 at an edge): CAP=0, PCNT=0, IDX=0, ACK=0. Resulting outputs: NIBBLE=0, DIGIT=0, ANODE = all ones except bit 0 = 0. Reset overrides LOAD and FREEZE. Mid-scan reset returns to digit 0 on the next edge.
- Capture: at an edge with LOAD=1, CAP<=BUSIN and ACK<=1; otherwise ACK<=0.
  - LOAD held high captures every cycle; ACK stays high correspondingly.
  - Capture never disturbs PCNT or IDX.
- Refresh: with FREEZE=0, PCNT increments each cycle. At PCNT=PRESCALE-1, PCNT<=0 and IDX<=IDX+1, wrapping DIGITS-1 -> 0. FREEZE=1 holds both PCNT and IDX; LOAD still works.
- PRESCALE=1: IDX advances every unfrozen cycle.
- Outputs are decoded directly from registered state, with no combinational path from inputs:
  - NIBBLE = CAP[4*IDX +: 4]
  - DIGIT = IDX
  - ANODE = ~(1<<IDX)
- Simultaneous LOAD and slot advance at one edge: both take effect. The next cycle shows the new CAP nibble at the new IDX.

## Timing
- LOAD edge -> ACK high and new value visible on NIBBLE one edge later (latency 1).
- Digit slot length is exactly PRESCALE cycles when FREEZE=0. A full scan takes DIGITS*PRESCALE cycles.
- ANODE, NIBBLE and DIGIT change together at the same edge; no glitch cycle is permitted between digits.
- Outputs are valid in the first cycle after reset release.

## Configuration
- BUSOUT_SCAN_BLANK_EN defined: leading-zero blanking.
  - A digit k>0 is blanked when CAP nibbles k..DIGITS-1 are all zero.
  - During a blanked digit's slot, ANODE is all ones; NIBBLE and DIGIT still follow IDX.
  - Digit 0 is never blanked.
  - Blanking is evaluated from CAP, so it changes one edge after the capture.
- BUSOUT_SCAN_BLANK_EN undefined: no blanking logic is compiled in; every slot drives its anode low.

## Test plan
Bench uses DIGITS=4, PRESCALE=4.
- Reset: hold RESETN=0 for 3 cycles, then release -> ANODE=4'b1110, NIBBLE=0, DIGIT=0, ACK=0. The first advance to DIGIT=1 occurs 4 edges after release.
- Capture and scan: pulse LOAD with BUSIN=16'h3A7C -> ACK high for exactly 1 cycle. NIBBLE then cycles C,7,A,3 with ANODE 1110,1101,1011,0111, 4 cycles each, and wraps back to C.
- Freeze: assert FREEZE for 10 cycles during DIGIT=2 -> DIGIT, ANODE and NIBBLE are constant. A LOAD during the freeze with 16'h0005 updates NIBBLE to 0 immediately after the capture edge. Scan resumes with the remaining slot count preserved.
- Simultaneous events: LOAD of 16'hBEEF on the same edge as the slot advance 0->1 -> the next cycle shows DIGIT=1, NIBBLE=E.
- Mid-scan reset: assert RESETN=0 at DIGIT=3 -> the next edge shows DIGIT=0, NIBBLE=0 (CAP cleared), ANODE=1110.
- Blanking (macro defined): capture 16'h0042 -> ANODE=1110 and 1101 in slots 0 and 1; 1111 in slots 2 and 3. Capture 16'h0000 -> only slot 0 is lit, with NIBBLE=0. Macro undefined: all four slots lit.
